// File: rtl/mainfsm_wait.sv
// Multicycle ARM main control FSM with a memory ready/request handshake,
// a bounded wait counter that traps to UNKNOWN on timeout, and a sticky fault.
module mainfsm_wait #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       mem_ready,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic       NextPC,
   output logic       RegW,
   output logic       MemW,
   output logic       Branch,
   output logic       ALUOp,
   output logic       mem_req,
   output logic       fault,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRd    = 4'd3,
      StMemWb    = 4'd4,
      StMemWr    = 4'd5,
      StExecuteR = 4'd6,
      StExecuteI = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
      StUnknown  = 4'd10
   } state_e;

   localparam bit               TimeoutEn  = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CntMax     = '1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mem_wait;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mem_wait = 1'b0;
      unique case (state_q)
         StFetch: begin
            mem_wait = !mem_ready;
            if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            case (Op)
               2'b00:   state_d = Funct[5] ? StExecuteI : StExecuteR;
               2'b01:   state_d = StMemAdr;
               2'b10:   state_d = StBranch;
               default: state_d = StUnknown;
            endcase
         end
         StExecuteR, StExecuteI: state_d = StAluWb;
         StAluWb:                state_d = StFetch;
         StMemAdr:               state_d = Funct[0] ? StMemRd : StMemWr;
         StMemRd: begin
            mem_wait = !mem_ready;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWr: begin
            mem_wait = !mem_ready;
            if (mem_ready) state_d = StFetch;
         end
         StMemWb, StBranch:      state_d = StFetch;
         StUnknown:              state_d = StUnknown;
         default:                state_d = StUnknown;
      endcase

      // A completing access (mem_ready=1) never trips the timeout.
      if (mem_wait && TimeoutEn && (cnt_q == TimeoutCnt)) state_d = StUnknown;

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (mem_wait && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_comb begin
      IRWrite   = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      NextPC    = 1'b0;
      RegW      = 1'b0;
      MemW      = 1'b0;
      Branch    = 1'b0;
      ALUOp     = 1'b0;
      mem_req   = 1'b0;
      fault     = 1'b0;
      unique case (state_q)
         StFetch: begin
            mem_req   = 1'b1;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            NextPC    = mem_ready;
         end
         StDecode: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
         end
         StExecuteR: ALUOp = 1'b1;
         StExecuteI: begin
            ALUSrcB = 2'b01;
            ALUOp   = 1'b1;
         end
         StAluWb:  RegW = 1'b1;
         StMemAdr: ALUSrcB = 2'b01;
         StMemRd: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
         end
         StMemWr: begin
            mem_req = 1'b1;
            AdrSrc  = 1'b1;
            MemW    = 1'b1;
         end
         StMemWb: begin
            ResultSrc = 2'b01;
            RegW      = 1'b1;
         end
         StBranch: begin
            Branch    = 1'b1;
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
         end
         StUnknown: fault = 1'b1;
         default: ;
      endcase
   end

   assign state_o = state_q;

endmodule

// File: doc/mainfsm_wait.md
Name: mainfsm_wait

Overview:
- Parametrised multicycle ARM main control FSM; successor to the fixed-latency controller.
- Implements the full instruction flow: data-processing register/immediate, LDR/STR, B.
- Adds a memory ready/request handshake with bounded wait, a timeout fault, and a sticky UNKNOWN trap state.
- Sits in the controller beside the ALU decoder and conditional logic; drives the multicycle datapath.

Parameters:
- TIMEOUT, 15, max consecutive wait cycles in a memory state before fault; 0 disables timeout.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- Op  input  2  instruction op field
- Funct  input  6  instruction funct field; [5]=I, [0]=L
- mem_ready  input  1  memory completes the current access this cycle
- IRWrite  output  1  instruction register write enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALU result
- ALUSrcA  output  2  ALU A select
- ALUSrcB  output  2  ALU B select
- ResultSrc  output  2  result mux select
- NextPC  output  1  PC update request
- RegW  output  1  register write (pre-condition)
- MemW  output  1  memory write (pre-condition)
- Branch  output  1  branch request
- ALUOp  output  1  1 = ALU decoder uses Funct; 0 = add
- mem_req  output  1  memory access in progress
- fault  output  1  timeout or illegal-op trap (sticky)
- state_o  output  4  current state, for debug

Behaviour:
- State encoding (4b): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10.
- Reset (async) sets state=FETCH, wait counter=0, fault=0. All outputs are Moore/combinational from state and mem_ready; after reset they carry the FETCH values below.
- Transitions:
  - FETCH -> DECODE only when mem_ready=1; otherwise hold.
  - DECODE: Op=00 -> EXECUTEI if Funct[5], else EXECUTER. Op=01 -> MEMADR. Op=10 -> BRANCH. Op=11 -> UNKNOWN.
  - EXECUTER, EXECUTEI -> ALUWB.
  - ALUWB -> FETCH.
  - MEMADR -> MEMRD if Funct[0], else MEMWR.
  - MEMRD -> MEMWB when mem_ready=1; otherwise hold.
  - MEMWR -> FETCH when mem_ready=1; otherwise hold.
  - MEMWB -> FETCH.
  - BRANCH -> FETCH.
  - UNKNOWN is terminal until reset. Any out-of-range encoding -> UNKNOWN.
- Wait counter:
  - Increments each cycle a memory state (FETCH/MEMRD/MEMWR) holds with mem_ready=0.
  - Clears on every state change.
  - If TIMEOUT != 0 and the counter equals TIMEOUT while mem_ready=0, next state is UNKNOWN.
  - mem_ready=1 in that same cycle wins: the access completes normally.
  - The counter saturates and never wraps.
- fault = 1 in UNKNOWN, else 0.
- Controls not listed for a state are 0 (no x outputs).
  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=mem_ready (strobe only on the completing cycle).
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - MEMADR: ALUSrcA=00, ALUSrcB=01.
  - MEMRD: mem_req=1, AdrSrc=1, ResultSrc=00.
  - MEMWR: mem_req=1, AdrSrc=1, MemW=1 (held for the whole wait), ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - BRANCH: Branch=1, ALUSrcA=10, ALUSrcB=01, ResultSrc=10.
  - UNKNOWN: all controls 0, fault=1.
- Latency with mem_ready tied to 1:
  - Data-processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
- Each added wait cycle adds one cycle to the instruction.
- Reset mid-operation aborts any state, including a pending MEMWR: MemW drops asynchronously.

Test Plan:
- Reset, mem_ready=1, Op=00, Funct=6'b100100 -> states 0,1,7,8,0; ALUOp=1 in state 7; RegW=1 only in state 8; IRWrite single pulse in state 0.
- Op=01, Funct[0]=1; mem_ready low 3 cycles in MEMRD, then high -> MEMRD lasts 4 cycles; counter reaches 3; then MEMWB with ResultSrc=01, RegW=1.
- Op=01, Funct[0]=0; mem_ready low in MEMWR -> MemW=1 and AdrSrc=1 held each cycle; exits to FETCH the cycle after mem_ready=1.
- FETCH with mem_ready=0 for 16 cycles (TIMEOUT=15) -> UNKNOWN on the 16th edge; fault=1 sticky despite later mem_ready=1 and any Op; cleared only by reset.
- Op=11 in DECODE -> UNKNOWN, fault=1. Op=10 -> BRANCH with Branch=1, ALUSrcA=10, ALUSrcB=01, then FETCH.
- Assert reset mid-MEMWR wait -> state_o=0 and MemW=0 immediately; next instruction fetched correctly after reset release.
